addsub_ctrl: RTL and testbench
==============================

Name: addsub_ctrl

Overview:
- Initiator/requester side of the addsub start/done handshake.
- Accepts operation commands from a host-side valid/ready port and drives `add_start`, `mode`, `op1` and `op2` into the adder.
- Waits for `add_done`, captures `add_result` and `add_overflow`, and presents them on a valid/ready response port.
- Adds a done-timeout watchdog and a saturating completed-operation counter for system status.

Parameters:
- RES_W, 14, width of the adder result bus.
- TIMEOUT, 64, maximum cycles in WAIT before the operation is aborted; must be at least 2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command
- cmd_mode  in  1  0 = add, 1 = subtract
- cmd_op1  in  32  IEEE-754 single operand 1
- cmd_op2  in  32  IEEE-754 single operand 2
- add_start  out  1  one-cycle start pulse to the adder
- mode  out  1  registered operation mode to the adder
- op1  out  32  registered operand 1 to the adder
- op2  out  32  registered operand 2 to the adder
- add_done  in  1  adder completion pulse
- add_result  in  RES_W  adder result
- add_overflow  in  1  adder overflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_result  out  RES_W  captured result
- rsp_overflow  out  1  captured overflow
- rsp_timeout  out  1  operation aborted by watchdog
- op_count  out  CNT_W  saturating count of responses accepted by host

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is asynchronous, active-high, on port `rst`.
- Reset values: all outputs are 0, `cmd_ready` is 0, state is IDLE, watchdog is 0.
  - `cmd_ready` rises in the first cycle after `rst` deasserts.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`: register `cmd_mode`/`cmd_op1`/`cmd_op2` into `mode`/`op1`/`op2`, then go to START.
  - `add_done` is ignored in IDLE.
- START:
  - `add_start` = 1 for exactly this one cycle.
  - `cmd_ready` = 0; watchdog cleared; go to WAIT.
- WAIT:
  - `add_start` = 0; watchdog increments each cycle.
  - On `add_done`: capture `add_result`/`add_overflow` into `rsp_result`/`rsp_overflow`, set `rsp_timeout` = 0, go to RESP.
  - If the watchdog reaches TIMEOUT-1 with no `add_done`: set `rsp_result` = 0, `rsp_overflow` = 0, `rsp_timeout` = 1, go to RESP.
  - If `add_done` arrives in the same cycle the watchdog expires, `add_done` wins.
- RESP:
  - `rsp_valid` = 1; response fields stay stable until `rsp_valid && rsp_ready`.
  - On that handshake: increment `op_count` (saturates at all-ones), go to IDLE.
  - `add_done` is ignored in RESP.
- Operand hold: `mode`/`op1`/`op2` are held constant from START until the next accepted command, including throughout WAIT.
- Latency: command accepted at cycle T.
  - `add_start` is high at T+1.
  - `add_done` is sampled from T+2 onward.
  - With `add_done` at cycle D, `rsp_valid` is high at D+1.
  - Minimum command-to-response latency is 3 cycles.
- Throughput: one outstanding operation. `cmd_ready` = 0 in START, WAIT and RESP. `cmd_ready` and `rsp_valid` are never both high.
- Reset mid-operation: returns immediately to IDLE. Any in-flight adder operation is abandoned and a later stray `add_done` is ignored in IDLE.
- No combinational paths from inputs to outputs; all outputs are registered or decoded from state.

Decomposition:
- `addsub_pkg`:
  - `ctrl_state_t` enum {IDLE, START, WAIT, RESP}.
  - Constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - Default RES_W = 14.
- Optional sub-module `watchdog_cnt`: clear/enable/expired, parameterized by TIMEOUT. Everything else stays in one module.

Test Plan:
- Basic add: `cmd_op1` = 0x3FA00000 (1.25), `cmd_op2` = 0x3FC00000 (1.50), mode 0; adder model returns `add_result` = 0x0B00 with `add_done` 4 cycles after start.
  - Required: `add_start` high for exactly one cycle at T+1.
  - Required: `op1`/`op2` held through WAIT.
  - Required: `rsp_valid` at D+1 with `rsp_result` = 0x0B00, `rsp_timeout` = 0, `op_count` = 1 after `rsp_ready`.
- Subtract with backpressure: `cmd_op1` = 0x3FC00000 (1.50), `cmd_op2` = 0x3FA00000 (1.25), mode 1; hold `rsp_ready` = 0 for 5 cycles.
  - Required: `rsp_valid` and `rsp_result` stable all 5 cycles, `cmd_ready` = 0, `op_count` unchanged until the handshake.
- Timeout: no `add_done`.
  - Required: `rsp_valid` exactly TIMEOUT cycles after START, with `rsp_timeout` = 1 and `rsp_result` = 0.
  - Required: an `add_done` pulse injected during RESP or IDLE produces no second response.
- Overflow and simultaneity:
  - Model asserts `add_overflow` = 1 with `add_done` → `rsp_overflow` = 1.
  - Second op with `add_done` at exactly watchdog = TIMEOUT-1 → `rsp_timeout` = 0 and the result is captured.
- Reset mid-WAIT and back-to-back:
  - Assert `rst` 2 cycles into WAIT → all outputs 0 asynchronously; `cmd_ready` = 1 one cycle after release.
  - Then issue 3 commands with `cmd_valid` held high → exactly 3 `add_start` pulses, one per operation, and `op_count` = 3.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract controller.
// The controller, its watchdog and the bench all import this package.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_t;

  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_SUB  = 1'b1;
  localparam int   DEF_RES_W = 14;

endpackage

// File: rtl/addsub_ctrl_if.sv
// Host command/response and adder start/done bus of the add/subtract controller.
// The slave modport is the controller; the master modport is its environment (host plus adder).
interface addsub_ctrl_if #(
  parameter int RES_W = 14,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [31:0]      cmd_op1;
  logic [31:0]      cmd_op2;
  logic             add_start;
  logic             mode;
  logic [31:0]      op1;
  logic [31:0]      op2;
  logic             add_done;
  logic [RES_W-1:0] add_result;
  logic             add_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_overflow;
  logic             rsp_timeout;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_op1, cmd_op2,
    input  add_done, add_result, add_overflow, rsp_ready,
    output cmd_ready, add_start, mode, op1, op2,
    output rsp_valid, rsp_result, rsp_overflow, rsp_timeout, op_count
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_op1, cmd_op2,
    output add_done, add_result, add_overflow, rsp_ready,
    input  cmd_ready, add_start, mode, op1, op2,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_timeout, op_count
  );
endinterface

// File: rtl/watchdog_cnt.sv
// Counts cycles since the start pulse; expired is high once the count reaches TIMEOUT-1.
// The count holds at TIMEOUT-1 so a late clear never sees a wrapped value.
module watchdog_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_reg;

  assign expired = (count_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end
endmodule

// File: rtl/addsub_ctrl.sv
// Requester side of the adder start/done handshake: one command in flight, watchdog abort,
// registered response and a saturating count of responses taken by the host.
module addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  addsub_ctrl_if.slave bus
);
  ctrl_state_t      state_reg, state_next;
  logic             cmd_ready_reg, add_start_reg, rsp_valid_reg;
  logic             mode_reg;
  logic [31:0]      op1_reg, op2_reg;
  logic [RES_W-1:0] rsp_result_reg;
  logic             rsp_overflow_reg, rsp_timeout_reg;
  logic [CNT_W-1:0] op_count_reg;
  logic             cmd_fire, rsp_fire;
  logic             wd_enable, wd_expired;

  // Handshakes use the registered flags so nothing is accepted in the first cycle out of reset.
  assign cmd_fire  = cmd_ready_reg & bus.cmd_valid;
  assign rsp_fire  = rsp_valid_reg & bus.rsp_ready;
  assign wd_enable = (state_reg == START) || (state_reg == WAIT);

  watchdog_cnt #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!wd_enable),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (bus.add_done || wd_expired) state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_reg    <= 1'b0;
      add_start_reg    <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      mode_reg         <= 1'b0;
      op1_reg          <= '0;
      op2_reg          <= '0;
      rsp_result_reg   <= '0;
      rsp_overflow_reg <= 1'b0;
      rsp_timeout_reg  <= 1'b0;
      op_count_reg     <= '0;
    end else begin
      cmd_ready_reg <= (state_next == IDLE);
      add_start_reg <= (state_next == START);
      rsp_valid_reg <= (state_next == RESP);
      if (cmd_fire) begin
        mode_reg <= bus.cmd_mode;
        op1_reg  <= bus.cmd_op1;
        op2_reg  <= bus.cmd_op2;
      end
      // A done pulse in the expiry cycle still delivers the real result.
      if (state_reg == WAIT) begin
        if (bus.add_done) begin
          rsp_result_reg   <= bus.add_result;
          rsp_overflow_reg <= bus.add_overflow;
          rsp_timeout_reg  <= 1'b0;
        end else if (wd_expired) begin
          rsp_result_reg   <= '0;
          rsp_overflow_reg <= 1'b0;
          rsp_timeout_reg  <= 1'b1;
        end
      end
      if (rsp_fire && (op_count_reg != '1)) begin
        op_count_reg <= op_count_reg + CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready    = cmd_ready_reg;
  assign bus.add_start    = add_start_reg;
  assign bus.mode         = mode_reg;
  assign bus.op1          = op1_reg;
  assign bus.op2          = op2_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_result   = rsp_result_reg;
  assign bus.rsp_overflow = rsp_overflow_reg;
  assign bus.rsp_timeout  = rsp_timeout_reg;
  assign bus.op_count     = op_count_reg;
endmodule

// File: tb/tb_addsub_ctrl.sv
// Bench for addsub_ctrl: behavioural adder with programmable done delay, response scoreboard,
// and directed latency/hold/timeout/reset checks.
module tb_addsub_ctrl;
  import addsub_pkg::*;

  localparam int RES_W   = 14;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;
  localparam logic [RES_W-1:0] JUNK = 14'h1555;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             ovf;
    logic             to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  addsub_ctrl_if #(.RES_W(RES_W), .CNT_W(CNT_W)) bus ();

  addsub_ctrl #(.RES_W(RES_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_starts = 0;
  int   n_rsp = 0;
  int   exp_count = 0;

  int               model_delay = -1;
  logic [RES_W-1:0] model_result = '0;
  logic             model_ovf = 1'b0;
  int               inject_req = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Adder model: done pulse model_delay cycles after the start cycle; junk result otherwise.
  initial begin
    int countdown;
    int inject_seen;
    countdown = -1;
    inject_seen = 0;
    bus.add_done = 1'b0;
    bus.add_result = JUNK;
    bus.add_overflow = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.add_done = 1'b0;
      bus.add_result = JUNK;
      bus.add_overflow = 1'b0;
      if (rst) begin
        countdown = -1;
      end else if (countdown == 0) begin
        bus.add_done = 1'b1;
        bus.add_result = model_result;
        bus.add_overflow = model_ovf;
        countdown = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
      if (inject_req != inject_seen) begin
        inject_seen = inject_req;
        bus.add_done = 1'b1;
      end
      if (bus.add_start && model_delay >= 0) countdown = model_delay - 1;
    end
  end

  // Monitor: exclusivity, response stability under backpressure, scoreboard pop on handshake.
  initial begin
    logic prev_hold;
    rsp_t prev, cur, e;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout};
      chk("rdy_valid_excl", 64'(bus.cmd_ready & bus.rsp_valid), 64'(0));
      if (bus.add_start) n_starts++;
      if (prev_hold && !rst) begin
        chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("hold_rsp_fields", 64'(cur), 64'(prev));
      end
      if (bus.rsp_valid && bus.rsp_ready && !rst) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(n_rsp), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", 64'(bus.rsp_result), 64'(e.result));
          chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(e.ovf));
          chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
          $display("rsp %0d @%0d: result=0x%h overflow=%0d timeout=%0d", n_rsp, cyc,
                   bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout);
        end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready && !rst;
      prev = cur;
    end
  end

  task automatic run_op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input logic [RES_W-1:0] res, input logic ovf,
                        input int hold, input logic inject_in_resp);
    int   t_acc, n, exp_lat;
    logic held_ok, hold_ok;
    rsp_t e;
    model_delay = delay;
    model_result = res;
    model_ovf = ovf;
    e.to = (delay < 0);
    e.result = e.to ? '0 : res;
    e.ovf = e.to ? 1'b0 : ovf;
    exp_lat = e.to ? TIMEOUT + 1 : delay + 2;
    bus.cmd_mode = m;
    bus.cmd_op1 = a;
    bus.cmd_op2 = b;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_accept_bound"}, 64'(n < 200), 64'(1));
    t_acc = cyc;
    exp_q.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
    chk({tag, "_start_hi"}, 64'(bus.add_start), 64'(1));
    chk({tag, "_ready_lo"}, 64'(bus.cmd_ready), 64'(0));
    tick();
    chk({tag, "_start_lo"}, 64'(bus.add_start), 64'(0));
    held_ok = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < TIMEOUT + 20) begin
      if ({bus.mode, bus.op1, bus.op2} !== {m, a, b}) held_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_ops_held"}, 64'(held_ok), 64'(1));
    chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(exp_lat));
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (i == 0 && inject_in_resp) inject_req++;
      if (bus.cmd_ready !== 1'b0 || bus.op_count !== CNT_W'(exp_count)) hold_ok = 1'b0;
      tick();
    end
    if (hold > 0) chk({tag, "_backpressure"}, 64'(hold_ok), 64'(1));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    chk({tag, "_op_count"}, 64'(bus.op_count), 64'(exp_count));
    chk({tag, "_valid_drop"}, 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    int n, starts0;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode = 1'b0;
    bus.cmd_op1 = '0;
    bus.cmd_op2 = '0;
    bus.rsp_ready = 1'b0;

    tick();
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rst_add_start", 64'(bus.add_start), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_op_count", 64'(bus.op_count), 64'(0));
    chk("rst_op1", 64'(bus.op1), 64'(0));
    rst = 1'b0;
    chk("rel_ready_lo", 64'(bus.cmd_ready), 64'(0));
    tick();
    chk("rel_ready_hi", 64'(bus.cmd_ready), 64'(1));

    run_op("add", MODE_ADD, 32'h3FA0_0000, 32'h3FC0_0000, 4, 14'h0B00, 1'b0, 0, 1'b0);
    run_op("sub", MODE_SUB, 32'h3FC0_0000, 32'h3FA0_0000, 3, 14'h0280, 1'b0, 5, 1'b0);
    run_op("tmo", MODE_ADD, 32'h4000_0000, 32'h4040_0000, -1, 14'h0000, 1'b0, 3, 1'b1);
    inject_req++;
    repeat (4) tick();
    chk("tmo_no_second_rsp", 64'(bus.rsp_valid), 64'(0));
    run_op("ovf", MODE_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 2, 14'h3FFF, 1'b1, 0, 1'b0);
    run_op("edge", MODE_SUB, 32'h4120_0000, 32'h3F80_0000, TIMEOUT - 1, 14'h0A5A, 1'b0, 1, 1'b0);

    // Reset two cycles into WAIT.
    model_delay = -1;
    bus.cmd_mode = MODE_SUB;
    bus.cmd_op1 = 32'hDEAD_BEEF;
    bus.cmd_op2 = 32'h1234_5678;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("rwait_accept_bound", 64'(n < 200), 64'(1));
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rwait_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rwait_add_start", 64'(bus.add_start), 64'(0));
    chk("rwait_ops", 64'({bus.mode, bus.op1}), 64'(0));
    chk("rwait_op2", 64'(bus.op2), 64'(0));
    chk("rwait_rsp", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout}), 64'(0));
    chk("rwait_op_count", 64'(bus.op_count), 64'(0));
    exp_q.delete();
    exp_count = 0;
    tick();
    rst = 1'b0;
    chk("rwait_rel_lo", 64'(bus.cmd_ready), 64'(0));
    inject_req++;
    tick();
    chk("rwait_rel_hi", 64'(bus.cmd_ready), 64'(1));
    repeat (3) tick();
    chk("rwait_stray_done", 64'(bus.rsp_valid), 64'(0));

    // Back-to-back with cmd_valid held high and the host always ready.
    model_delay = 2;
    model_result = 14'h0123;
    model_ovf = 1'b0;
    bus.rsp_ready = 1'b1;
    starts0 = n_starts;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_mode = i[0];
      bus.cmd_op1 = 32'h3F80_0000 + 32'(i);
      bus.cmd_op2 = 32'h4000_0000 + 32'(i);
      n = 0;
      while (!bus.cmd_ready && n < 200) begin
        tick();
        n++;
      end
      chk("b2b_accept_bound", 64'(n < 200), 64'(1));
      exp_q.push_back({14'h0123, 1'b0, 1'b0});
      tick();
    end
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.op_count != CNT_W'(3) && n < 100) begin
      tick();
      n++;
    end
    tick();
    bus.rsp_ready = 1'b0;
    chk("b2b_op_count", 64'(bus.op_count), 64'(3));
    chk("b2b_starts", 64'(n_starts - starts0), 64'(3));
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
